// File: rtl/regfile_pkg.sv
// Shared mode encodings and helpers for the multimode user register file.
package regfile_pkg;

  localparam logic [1:0] MODE_RW  = 2'd0;
  localparam logic [1:0] MODE_RO  = 2'd1;
  localparam logic [1:0] MODE_W1P = 2'd2;
  localparam logic [1:0] MODE_COR = 2'd3;

  localparam int MAX_REGS = 64;
  localparam int unsigned DEFAULT_BASE = 32'h10;

  // Mode table is passed zero-extended to the maximum slot count.
  function automatic logic [1:0] slot_mode(input logic [2*MAX_REGS-1:0] modes, input int k);
    return modes[2*k +: 2];
  endfunction

endpackage

// File: rtl/regfile_slot.sv
// One register slot; behaviour selected by a tie-off mode (RW, RO, W1P, COR).
module regfile_slot
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] rst_val,
  input  logic                  wr_hit,
  input  logic                  rd_hit,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] ext_in,
  output logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] rd_val,
  output logic                  wr_strb
);

  // Single storage register: RW value, W1P pulse or COR sticky bits.
  logic [DATA_WIDTH-1:0] val, val_nxt;

  always_comb begin
    val_nxt = val;
    case (mode)
      MODE_RW:  if (wr_hit) val_nxt = wr_data;
      MODE_W1P: val_nxt = wr_hit ? wr_data : '0;
      // New events on the clearing cycle survive the clear.
      MODE_COR: val_nxt = (rd_hit ? '0 : val) | ext_in;
      default:  val_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      val     <= (mode == MODE_RW) ? rst_val : '0;
      wr_strb <= 1'b0;
    end else begin
      val     <= val_nxt;
      wr_strb <= wr_hit;
    end
  end

  always_comb begin
    rd_val = '0;
    q      = '0;
    case (mode)
      MODE_RW:  begin rd_val = val; q = val; end
      MODE_RO:  rd_val = ext_in;
      MODE_W1P: q = val;
      MODE_COR: rd_val = val;
      default:  rd_val = '0;
    endcase
  end

endmodule

// File: rtl/regfile_multimode.sv
// Parametrised user register file: address decode, ack/error pipeline and registered read mux.
module regfile_multimode
  import regfile_pkg::*;
#(
  parameter int                          ADDR_WIDTH = 14,
  parameter int                          DATA_WIDTH = 32,
  parameter int                          NUM_REGS   = 5,
  parameter int unsigned                 BASE_ADDR  = DEFAULT_BASE,
  parameter logic [2*NUM_REGS-1:0]       REG_MODE   = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RST_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst_i,
  input  logic [ADDR_WIDTH-1:0]          addr_i,
  input  logic                           wr_i,
  input  logic [DATA_WIDTH-1:0]          wr_data_i,
  output logic                           wr_ack_o,
  input  logic                           rd_i,
  output logic                           rd_ack_o,
  output logic [DATA_WIDTH-1:0]          rd_data_o,
  output logic                           addr_err_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] regs_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_strb_o
);

  logic [NUM_REGS-1:0]                 sel;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] rd_val;
  logic [DATA_WIDTH-1:0]               rd_mux;
  logic                                hit;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_slot
    localparam logic [ADDR_WIDTH-1:0] SLOT_ADDR = ADDR_WIDTH'(BASE_ADDR + k);
    localparam logic [1:0] MODE = slot_mode((2*MAX_REGS)'(REG_MODE), k);

    assign sel[k] = (addr_i == SLOT_ADDR);

    regfile_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
      .clk     (clk),
      .rst_i   (rst_i),
      .mode    (MODE),
      .rst_val (RST_VAL[k*DATA_WIDTH +: DATA_WIDTH]),
      .wr_hit  (wr_i & sel[k]),
      .rd_hit  (rd_i & sel[k]),
      .wr_data (wr_data_i),
      .ext_in  (regs_i[k*DATA_WIDTH +: DATA_WIDTH]),
      .q       (regs_o[k*DATA_WIDTH +: DATA_WIDTH]),
      .rd_val  (rd_val[k]),
      .wr_strb (wr_strb_o[k])
    );
  end

  assign hit = |sel;

  // One-hot select, so an OR-reduction is the mux; a miss yields zero.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (sel[k]) rd_mux = rd_mux | rd_val[k];
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ack_o   <= 1'b0;
      rd_ack_o   <= 1'b0;
      rd_data_o  <= '0;
      addr_err_o <= 1'b0;
    end else begin
      wr_ack_o   <= wr_i;
      rd_ack_o   <= rd_i;
      addr_err_o <= (wr_i | rd_i) & ~hit;
      if (rd_i) rd_data_o <= rd_mux;
    end
  end

endmodule
